// File: rtl/battleship_pkg.sv
// Shared types and constants for the Battleship seven-segment display path.
// Segments are active-low, so an all-ones frame is a dark display.
package battleship_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      DONE = 2'd2
   } seq_state_t;

   localparam int SCREEN_W_DEFAULT = 28;

   localparam logic [SCREEN_W_DEFAULT-1:0] SEG_BLANK = '1;

   // A request for zero slots still shows slot 0; oversized requests saturate.
   function automatic int clamp_active(input int n, input int max_n);
      if (n < 1) begin
         return 1;
      end
      if (n > max_n) begin
         return max_n;
      end
      return n;
   endfunction

endpackage

// File: rtl/battleship_screen_sequencer_dwell_counter.sv
// Counts qualifying strobe ticks within one frame and flags the tick that
// ends the dwell so the sequencer can advance to the next slot.
module dwell_counter #(
   parameter int DWELL_TICKS = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic wrap
);

   localparam int CW = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;
   localparam logic [CW-1:0] MAX_COUNT = CW'(DWELL_TICKS - 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   assign wrap = en & (count_q == MAX_COUNT);

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en) begin
         count_d = (count_q == MAX_COUNT) ? '0 : count_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/battleship_screen_sequencer.sv
// Steps through packed seven-segment frames, dwelling a fixed number of
// strobe ticks on each, with loop/one-shot playback, pause and restart.
module battleship_screen_sequencer
   import battleship_pkg::*;
#(
   parameter int                    N_SCREENS   = 4,
   parameter int                    SCREEN_W    = SCREEN_W_DEFAULT,
   parameter int                    DWELL_TICKS = 2,
   parameter logic [SCREEN_W-1:0]   BLANK       = {SCREEN_W{1'b1}},
   localparam int                   IW          = (N_SCREENS > 1) ? $clog2(N_SCREENS) : 1,
   localparam int                   NW          = $clog2(N_SCREENS + 1)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          tick,
   input  logic [N_SCREENS*SCREEN_W-1:0] screens,
   input  logic [NW-1:0]                 n_active,
   input  logic                          loop_mode,
   input  logic                          start,
   input  logic                          pause,
   output logic [SCREEN_W-1:0]           ships,
   output logic [IW-1:0]                 index,
   output logic                          busy,
   output logic                          done
);

   seq_state_t          state_q;
   logic [IW-1:0]       index_q;
   logic [IW-1:0]       last_q;
   logic [IW-1:0]       last_d;
   logic                loop_q;
   logic [SCREEN_W-1:0] ships_q;
   logic                busy_q;
   logic                done_q;

   logic                dwell_en;
   logic                dwell_wrap;
   logic [SCREEN_W-1:0] frames [N_SCREENS];
   logic [SCREEN_W-1:0] cur_frame;

   for (genvar k = 0; k < N_SCREENS; k++) begin : g_frames
      assign frames[k] = screens[k*SCREEN_W +: SCREEN_W];
   end

   assign cur_frame = frames[index_q];

   always_comb begin
      last_d = IW'(clamp_active(int'(n_active), N_SCREENS) - 1);
   end

   // Ticks only matter while showing; pausing drops them rather than queueing.
   assign dwell_en = tick & ~pause & (state_q == SHOW);

   dwell_counter #(
      .DWELL_TICKS(DWELL_TICKS)
   ) u_dwell (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (dwell_en),
      .clr  (start),
      .wrap (dwell_wrap)
   );

   // start overrides everything; the output frame lags the slot index by one cycle
   // and is re-read from the live bus every cycle so edits show while dwelling.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         index_q <= '0;
         last_q  <= '0;
         loop_q  <= 1'b0;
         ships_q <= BLANK;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q  <= 1'b0;
         ships_q <= (state_q == IDLE) ? BLANK : cur_frame;
         if (start) begin
            state_q <= SHOW;
            index_q <= '0;
            last_q  <= last_d;
            loop_q  <= loop_mode;
            busy_q  <= 1'b1;
         end else if ((state_q == SHOW) && dwell_wrap) begin
            if (index_q < last_q) begin
               index_q <= index_q + IW'(1);
            end else if (loop_q) begin
               index_q <= '0;
            end else begin
               state_q <= DONE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end
         end
      end
   end

   assign ships = ships_q;
   assign index = index_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: tb/tb_battleship_screen_sequencer.sv
// Self-checking bench for battleship_screen_sequencer: directed scenarios plus
// randomized traffic, compared every cycle against a tick-count reference model.
module tb_battleship_screen_sequencer;

   localparam int N = 4;
   localparam int W = 28;
   localparam int D = 2;
   localparam logic [W-1:0] BLANK_FRAME = 28'hFFFFFFF;

   logic           clk = 1'b0;
   logic           rst_n = 1'b1;
   logic           tick = 1'b0;
   logic [N*W-1:0] screens;
   logic [2:0]     n_active = 3'd0;
   logic           loop_mode = 1'b0;
   logic           start = 1'b0;
   logic           pause = 1'b0;
   logic [W-1:0]   ships;
   logic [1:0]     index;
   logic           busy;
   logic           done;

   int checks = 0;
   int failures = 0;

   // Reference model: playback position is just a count of qualifying ticks.
   int           mMode = 0;
   int           mTicks = 0;
   int           mN = 1;
   bit           mLoop = 1'b0;
   logic [W-1:0] mShips = BLANK_FRAME;
   int           mIndex = 0;
   bit           mDone = 1'b0;

   battleship_screen_sequencer #(
      .N_SCREENS  (N),
      .SCREEN_W   (W),
      .DWELL_TICKS(D)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick),
      .screens  (screens),
      .n_active (n_active),
      .loop_mode(loop_mode),
      .start    (start),
      .pause    (pause),
      .ships    (ships),
      .index    (index),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] frameOf(input int s);
      return screens[s*W +: W];
   endfunction

   function automatic int curSlot();
      if (mMode == 0) return 0;
      if (mMode == 2) return mN - 1;
      return (mTicks / D) % mN;
   endfunction

   task automatic modelEdge();
      mShips = (mMode == 0) ? BLANK_FRAME : frameOf(curSlot());
      mDone = 1'b0;
      if (start) begin
         mMode = 1;
         mTicks = 0;
         mN = (n_active == 0) ? 1 : ((int'(n_active) > N) ? N : int'(n_active));
         mLoop = loop_mode;
      end else if (mMode == 1 && tick && !pause) begin
         mTicks++;
         if (mTicks == mN * D) begin
            if (mLoop) begin
               mTicks = 0;
            end else begin
               mMode = 2;
               mDone = 1'b1;
            end
         end
      end
      mIndex = curSlot();
   endtask

   task automatic modelReset();
      mMode = 0;
      mTicks = 0;
      mShips = BLANK_FRAME;
      mIndex = 0;
      mDone = 1'b0;
   endtask

   task automatic checkAll();
      checkOutput("ships", 32'(ships), 32'(mShips));
      checkOutput("index", 32'(index), 32'(mIndex));
      checkOutput("busy", 32'(busy), 32'(mMode == 1));
      checkOutput("done", 32'(done), 32'(mDone));
   endtask

   task automatic applyStimulus(input bit st, input bit pa, input bit tk);
      start = st;
      pause = pa;
      tick = tk;
      @(posedge clk);
      if (rst_n) modelEdge();
      #1;
      checkAll();
   endtask

   task automatic assertReset();
      rst_n = 1'b0;
      modelReset();
      #1;
      checkOutput("rstShips", 32'(ships), 32'(BLANK_FRAME));
      checkOutput("rstBusy", 32'(busy), 32'd0);
      checkOutput("rstIndex", 32'(index), 32'd0);
      checkOutput("rstDone", 32'(done), 32'd0);
   endtask

   int expLoop [10];
   int doneCount;

   initial begin
      expLoop = '{1, 1, 2, 2, 3, 3, 4, 4, 1, 1};
      screens = {28'h0000004, 28'h0000003, 28'h0000002, 28'h0000001};

      #2;
      assertReset();
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);
      rst_n = 1'b1;

      $display("[TB] idle after reset");
      repeat (20) begin
         applyStimulus(1'b0, 1'b0, 1'b1);
         checkOutput("idleShips", 32'(ships), 32'(BLANK_FRAME));
      end

      $display("[TB] looping playback of four slots");
      n_active = 3'd4;
      loop_mode = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b1);
      doneCount = 0;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1);
         checkOutput("loopSeq", 32'(ships), 32'(expLoop[i]));
         if (done) doneCount++;
      end
      repeat (8) begin
         applyStimulus(1'b0, 1'b0, 1'b1);
         if (done) doneCount++;
      end
      checkOutput("loopNoDone", 32'(doneCount), 32'd0);

      $display("[TB] one-shot playback of three slots");
      n_active = 3'd3;
      loop_mode = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b1);
      doneCount = 0;
      repeat (12) begin
         applyStimulus(1'b0, 1'b0, 1'b1);
         if (done) begin
            doneCount++;
            checkOutput("busyFallsWithDone", 32'(busy), 32'd0);
         end
      end
      checkOutput("oneShotDoneCount", 32'(doneCount), 32'd1);
      checkOutput("oneShotHold", 32'(ships), 32'h3);

      $display("[TB] pause during slot 2");
      n_active = 3'd4;
      loop_mode = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b1);
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);
      repeat (5) begin
         applyStimulus(1'b0, 1'b1, 1'b1);
         checkOutput("pauseIndex", 32'(index), 32'd1);
         checkOutput("pauseShips", 32'(ships), 32'h2);
      end
      repeat (6) applyStimulus(1'b0, 1'b0, 1'b1);

      $display("[TB] n_active clamping and restart");
      n_active = 3'd0;
      loop_mode = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b1);
      repeat (8) applyStimulus(1'b0, 1'b0, 1'b1);
      n_active = 3'd7;
      loop_mode = 1'b0;
      applyStimulus(1'b1, 1'b0, 1'b1);
      repeat (5) applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1);
      repeat (12) applyStimulus(1'b0, 1'b0, 1'b1);

      $display("[TB] start colliding with final tick");
      n_active = 3'd1;
      applyStimulus(1'b1, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1);
      repeat (4) applyStimulus(1'b0, 1'b0, 1'b1);

      $display("[TB] asynchronous reset mid-playback");
      n_active = 3'd4;
      loop_mode = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b1);
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);
      assertReset();
      repeat (2) applyStimulus(1'b0, 1'b0, 1'b1);
      rst_n = 1'b1;
      repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);

      $display("[TB] live frame edit");
      applyStimulus(1'b1, 1'b0, 1'b1);
      repeat (2) applyStimulus(1'b0, 1'b0, 1'b1);
      screens[1*W +: W] = 28'h00000AA;
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("liveEdit", 32'(ships), 32'h00000AA);
      screens[1*W +: W] = 28'h0000002;
      repeat (4) applyStimulus(1'b0, 1'b0, 1'b1);

      $display("[TB] randomized traffic");
      for (int c = 0; c < 400; c++) begin
         n_active = 3'($urandom_range(0, 7));
         loop_mode = 1'($urandom);
         if ($urandom_range(0, 9) == 0) begin
            screens[$urandom_range(0, N - 1)*W +: W] = 28'($urandom);
         end
         applyStimulus($urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0, 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
